// File: rtl/booth_divider_seq.sv
// Sequential signed restoring divider: 2*D_SIZE-bit dividend / D_SIZE-bit divisor, one quotient bit per clock.
// Optional macro BOOTH_DIV_SATURATE_EN: saturate Quotient on overflow instead of forcing it to zero.
module booth_divider_seq #(
  parameter int D_SIZE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2*D_SIZE-1:0]   Dividend,
  input  logic [D_SIZE-1:0]     Divisor,
  output logic [D_SIZE-1:0]     Quotient,
  output logic [D_SIZE-1:0]     Remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  div_by_zero
);

  localparam int W     = 2 * D_SIZE;
  localparam int CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(W - 1);
  localparam logic signed [W:0] Q_MAX = (W + 1)'(2 ** (D_SIZE - 1) - 1);
  localparam logic signed [W:0] Q_MIN = -((W + 1)'(2 ** (D_SIZE - 1)));

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    ADJ,
    LOAD,
    DONE
  } state_t;

  state_t state, next_state;

  logic [CNT_W-1:0]  count;
  logic [W-1:0]      quo;
  logic [D_SIZE-1:0] rem;
  logic [D_SIZE-1:0] dvs_mag;
  logic              neg_dvd;
  logic              neg_dvs;
  logic              dvs_zero;

  logic [D_SIZE-1:0] q_res;
  logic [D_SIZE-1:0] r_res;
  logic              ov_res;
  logic              dz_res;

  logic [W-1:0]        dvd_mag_in;
  logic [D_SIZE-1:0]   dvs_mag_in;
  logic [D_SIZE:0]     trial;
  logic [W:0]          q_wide;
  logic signed [W:0]   q_signed;
  logic [D_SIZE-1:0]   r_signed;
  logic                q_fits;
  logic [D_SIZE-1:0]   q_adj;
  logic [D_SIZE-1:0]   r_adj;
  logic                ov_adj;
  logic                dz_adj;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CALC;
      CALC:    if (count == LAST) next_state = ADJ;
      ADJ:     next_state = LOAD;
      LOAD:    next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Control outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      CALC, ADJ, LOAD: busy = 1'b1;
      DONE:            done = 1'b1;
      default:         ;
    endcase
  end

  // Magnitudes are unsigned, so the most negative operand maps to 2^(n-1) without wrapping.
  always_comb begin
    dvd_mag_in = Dividend[W-1]      ? (~Dividend + 1'b1) : Dividend;
    dvs_mag_in = Divisor[D_SIZE-1]  ? (~Divisor + 1'b1)  : Divisor;
    trial      = {rem, quo[W-1]} - {1'b0, dvs_mag};
  end

  always_comb begin
    q_wide   = {1'b0, quo};
    q_signed = (neg_dvd ^ neg_dvs) ? -q_wide : q_wide;
    r_signed = neg_dvd ? -rem : rem;
    q_fits   = (q_signed >= Q_MIN) && (q_signed <= Q_MAX);
  end

  always_comb begin
    q_adj  = q_signed[D_SIZE-1:0];
    r_adj  = r_signed;
    ov_adj = 1'b0;
    dz_adj = 1'b0;
    if (dvs_zero) begin
      q_adj  = '0;
      r_adj  = '0;
      dz_adj = 1'b1;
    end else if (!q_fits) begin
      r_adj  = '0;
      ov_adj = 1'b1;
`ifdef BOOTH_DIV_SATURATE_EN
      q_adj  = (neg_dvd ^ neg_dvs) ? Q_MIN[D_SIZE-1:0] : Q_MAX[D_SIZE-1:0];
`else
      q_adj  = '0;
`endif
    end
  end

  // Datapath; a restore keeps the shifted partial remainder, whose top bit is always 0 then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      quo         <= '0;
      rem         <= '0;
      dvs_mag     <= '0;
      neg_dvd     <= 1'b0;
      neg_dvs     <= 1'b0;
      dvs_zero    <= 1'b0;
      q_res       <= '0;
      r_res       <= '0;
      ov_res      <= 1'b0;
      dz_res      <= 1'b0;
      Quotient    <= '0;
      Remainder   <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            quo      <= dvd_mag_in;
            rem      <= '0;
            dvs_mag  <= dvs_mag_in;
            neg_dvd  <= Dividend[W-1];
            neg_dvs  <= Divisor[D_SIZE-1];
            dvs_zero <= (Divisor == '0);
            count    <= '0;
          end
        end
        CALC: begin
          quo   <= {quo[W-2:0], ~trial[D_SIZE]};
          rem   <= trial[D_SIZE] ? {rem[D_SIZE-2:0], quo[W-1]} : trial[D_SIZE-1:0];
          count <= count + 1'b1;
        end
        ADJ: begin
          q_res  <= q_adj;
          r_res  <= r_adj;
          ov_res <= ov_adj;
          dz_res <= dz_adj;
        end
        LOAD: begin
          Quotient    <= q_res;
          Remainder   <= r_res;
          overflow    <= ov_res;
          div_by_zero <= dz_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_divider_seq.sv
// Directed self-checking bench for booth_divider_seq (D_SIZE=4); honours BOOTH_DIV_SATURATE_EN.
module tb_booth_divider_seq;

  localparam int D = 4;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [2*D-1:0] Dividend;
  logic [D-1:0]   Divisor;
  logic [D-1:0]   Quotient;
  logic [D-1:0]   Remainder;
  logic           busy;
  logic           done;
  logic           overflow;
  logic           div_by_zero;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  booth_divider_seq #(.D_SIZE(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .Dividend    (Dividend),
    .Divisor     (Divisor),
    .Quotient    (Quotient),
    .Remainder   (Remainder),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One division with latency, busy-length and result checks.
  task automatic do_div(input string tag, input logic [2*D-1:0] dvd, input logic [D-1:0] dvs,
                        input logic [D-1:0] eq, input logic [D-1:0] er,
                        input logic eov, input logic edz);
    int unsigned busy_cycles;
    int unsigned done_at;
    @(negedge clk);
    Dividend = dvd;
    Divisor  = dvs;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    busy_cycles = busy ? 1 : 0;
    done_at     = 0;
    for (int j = 1; j <= 13 && done_at == 0; j++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cycles++;
      if (done) done_at = j;
    end
    check({tag, "_latency"}, done_at, 10);
    check({tag, "_busy_cycles"}, busy_cycles, 10);
    check({tag, "_quotient"}, Quotient, eq);
    check({tag, "_remainder"}, Remainder, er);
    check({tag, "_overflow"}, overflow, eov);
    check({tag, "_div_by_zero"}, div_by_zero, edz);
    @(posedge clk);
    #1;
    check({tag, "_done_low"}, done, 0);
    check({tag, "_hold_q"}, Quotient, eq);
  endtask

  logic [D-1:0] sat_pos;
  logic [D-1:0] sat_neg;
  int unsigned  dones;

  initial begin
`ifdef BOOTH_DIV_SATURATE_EN
    sat_pos = 4'h7;
    sat_neg = 4'h8;
`else
    sat_pos = 4'h0;
    sat_neg = 4'h0;
`endif
    rst_n    = 1'b0;
    start    = 1'b0;
    Dividend = '0;
    Divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_quotient", Quotient, 0);
    check("rst_remainder", Remainder, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_flags", {overflow, div_by_zero}, 0);
    @(negedge clk) rst_n = 1'b1;

    do_div("d30_5",    8'h1E, 4'h5, 4'h6, 4'h0, 1'b0, 1'b0);
    do_div("dm20_3",   8'hEC, 4'h3, 4'hA, 4'hE, 1'b0, 1'b0);
    do_div("d23_m4",   8'h17, 4'hC, 4'hB, 4'h3, 1'b0, 1'b0);
    do_div("dm35_5",   8'hDD, 4'h5, 4'h9, 4'h0, 1'b0, 1'b0);
    do_div("dm32_4",   8'hE0, 4'h4, 4'h8, 4'h0, 1'b0, 1'b0);
    do_div("dm56_m8",  8'hC8, 4'h8, 4'h7, 4'h0, 1'b0, 1'b0);
    do_div("dm64_m8",  8'hC0, 4'h8, sat_pos, 4'h0, 1'b1, 1'b0);
    do_div("d100_3",   8'h64, 4'h3, sat_pos, 4'h0, 1'b1, 1'b0);
    do_div("dm128_m1", 8'h80, 4'hF, sat_pos, 4'h0, 1'b1, 1'b0);
    do_div("dm100_2",  8'h9C, 4'h2, sat_neg, 4'h0, 1'b1, 1'b0);
    do_div("d45_0",    8'h2D, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    do_div("dm7_2",    8'hF9, 4'h2, 4'hD, 4'hF, 1'b0, 1'b0);

    // Extra start pulses while busy and during the done cycle must be ignored.
    @(negedge clk);
    Dividend = 8'h1E;
    Divisor  = 4'h5;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dones = 0;
    for (int j = 1; j <= 14; j++) begin
      if (j == 3 || j == 11) begin
        @(negedge clk);
        Dividend = 8'h64;
        Divisor  = 4'h3;
        start    = 1'b1;
      end
      @(posedge clk);
      #1 start = 1'b0;
      if (done) dones++;
      if (j == 12) check("ign_busy_after_done", busy, 0);
    end
    check("ign_done_count", dones, 1);
    check("ign_quotient", Quotient, 4'h6);
    check("ign_overflow", overflow, 0);

    // Asynchronous reset in flight clears everything and suppresses done.
    @(negedge clk);
    Dividend = 8'h17;
    Divisor  = 4'hC;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_quotient", Quotient, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk) rst_n = 1'b1;
    dones = 0;
    for (int j = 0; j < 14; j++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    check("abort_idle_busy", busy, 0);

    do_div("after_abort", 8'hEC, 4'h3, 4'hA, 4'hE, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
